// File: rtl/param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : param_datapath
// Purpose  : Parametrised register-file / ALU datapath. One instruction is
//            accepted per cycle over a valid/ready handshake, its result is
//            captured into a writeback (W) stage and committed to the
//            register file on the following edge. Operands are bypassed from
//            W so back-to-back dependent instructions see the newest value.
//            Zero/carry flags track the last ALU instruction.
// Options  : MULT_EN - when defined, opcode 1110 runs a WIDTH-cycle
//            shift-add multiplier that deasserts in_ready while it runs.
//            When undefined, 1110 is a single-cycle op returning 0 and
//            busy is tied low.
// Ports    : clk, reset (sync, active-high)
//            in_valid/in_ready      - issue handshake
//            muxSel, inputData      - load path select and load value
//            dstSel, A_sel, B_sel   - destination and operand registers
//            OP_Sel                 - ALU opcode
//            wb_valid/wb_dst/wb_data- writeback stage contents
//            flag_zero, flag_carry  - status of last ALU result
//            busy                   - multiplier running
//            rd_sel/rd_data         - debug read port (no bypass)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module param_datapath #(
    parameter int WIDTH = 8,
    parameter int NREGS = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             muxSel,
    input  logic [WIDTH-1:0] inputData,
    input  logic [SEL_W-1:0] dstSel,
    input  logic [SEL_W-1:0] A_sel,
    input  logic [SEL_W-1:0] B_sel,
    input  logic [3:0]       OP_Sel,
    output logic             wb_valid,
    output logic [SEL_W-1:0] wb_dst,
    output logic [WIDTH-1:0] wb_data,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             busy,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [3:0] c_OP_ZERO = 4'b0000;
    localparam logic [3:0] c_OP_PASS = 4'b0001;
    localparam logic [3:0] c_OP_INC  = 4'b0010;
    localparam logic [3:0] c_OP_DEC  = 4'b0011;
    localparam logic [3:0] c_OP_ADD  = 4'b0100;
    localparam logic [3:0] c_OP_NEG  = 4'b0101;
    localparam logic [3:0] c_OP_AND  = 4'b0110;
    localparam logic [3:0] c_OP_OR   = 4'b0111;
    localparam logic [3:0] c_OP_EQ   = 4'b1000;
    localparam logic [3:0] c_OP_GT   = 4'b1001;
    localparam logic [3:0] c_OP_XOR  = 4'b1010;
    localparam logic [3:0] c_OP_SUB  = 4'b1011;
    localparam logic [3:0] c_OP_SHL  = 4'b1100;
    localparam logic [3:0] c_OP_SHR  = 4'b1101;
    localparam logic [3:0] c_OP_MUL  = 4'b1110;
    localparam logic [3:0] c_OP_NOT  = 4'b1111;

    localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   c_ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_wbValid;
    logic [SEL_W-1:0] r_wbDst;
    logic [WIDTH-1:0] r_wbData;
    logic             r_flagZero;
    logic             r_flagCarry;

    logic             w_accept;
    logic [WIDTH-1:0] w_opA;
    logic [WIDTH-1:0] w_opB;
    logic [WIDTH:0]   w_addSum;
    logic [WIDTH:0]   w_subSum;
    logic [WIDTH:0]   w_incSum;
    logic [WIDTH:0]   w_decSum;
    logic [WIDTH-1:0] w_aluRes;
    logic             w_aluCarry;

    logic             w_mulStart;
    logic             w_mulDone;
    logic [WIDTH-1:0] w_mulResult;
    logic [SEL_W-1:0] w_mulDst;

    assign w_accept = in_valid && in_ready;

    // Operand read with bypass from W: the register file only sees the W
    // value one edge later, so the newest value for that register lives in W.
    assign w_opA = (r_wbValid && (r_wbDst == A_sel)) ? r_wbData : r_regs[A_sel];
    assign w_opB = (r_wbValid && (r_wbDst == B_sel)) ? r_wbData : r_regs[B_sel];

    // Subtractions are formed as A + ~B + 1 so the top bit is "no borrow".
    assign w_addSum = {1'b0, w_opA} + {1'b0, w_opB};
    assign w_subSum = {1'b0, w_opA} + {1'b0, ~w_opB} + c_ONE_EXT;
    assign w_incSum = {1'b0, w_opA} + c_ONE_EXT;
    assign w_decSum = {1'b0, w_opA} + {1'b0, ~c_ONE} + c_ONE_EXT;

    always_comb begin
        w_aluRes   = '0;
        w_aluCarry = 1'b0;
        case (OP_Sel)
            c_OP_ZERO: w_aluRes = '0;
            c_OP_PASS: w_aluRes = w_opA;
            c_OP_INC:  {w_aluCarry, w_aluRes} = w_incSum;
            c_OP_DEC:  {w_aluCarry, w_aluRes} = w_decSum;
            c_OP_ADD:  {w_aluCarry, w_aluRes} = w_addSum;
            c_OP_NEG:  w_aluRes = ~w_opA + c_ONE;
            c_OP_AND:  w_aluRes = w_opA & w_opB;
            c_OP_OR:   w_aluRes = w_opA | w_opB;
            c_OP_EQ:   w_aluRes = {{(WIDTH-1){1'b0}}, (w_opA == w_opB)};
            c_OP_GT:   w_aluRes = {{(WIDTH-1){1'b0}}, (w_opA > w_opB)};
            c_OP_XOR:  w_aluRes = w_opA ^ w_opB;
            c_OP_SUB:  {w_aluCarry, w_aluRes} = w_subSum;
            // A shift amount >= WIDTH shifts every bit out, giving 0.
            c_OP_SHL:  w_aluRes = w_opA << w_opB;
            c_OP_SHR:  w_aluRes = w_opA >> w_opB;
            // Single-cycle value for 1110; the multiplier (if present)
            // bypasses this path entirely.
            c_OP_MUL:  w_aluRes = '0;
            c_OP_NOT:  w_aluRes = ~w_opA;
            default:   w_aluRes = '0;
        endcase
    end

`ifdef MULT_EN
    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic               r_busy;
    logic [c_CNT_W-1:0] r_mulCnt;
    logic [WIDTH-1:0]   r_mulAcc;
    logic [WIDTH-1:0]   r_mulCand;
    logic [WIDTH-1:0]   r_mulPlier;
    logic [SEL_W-1:0]   r_mulDst;
    logic [WIDTH-1:0]   w_mulAdd;

    assign w_mulStart  = w_accept && !muxSel && (OP_Sel == c_OP_MUL);
    // One partial product per cycle; only the low WIDTH bits are kept.
    assign w_mulAdd    = r_mulAcc + (r_mulPlier[0] ? r_mulCand : '0);
    // The last step's sum goes straight to W on the edge busy falls.
    assign w_mulDone   = r_busy && (r_mulCnt == c_CNT_LAST);
    assign w_mulResult = w_mulAdd;
    assign w_mulDst    = r_mulDst;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_mulCnt   <= '0;
            r_mulAcc   <= '0;
            r_mulCand  <= '0;
            r_mulPlier <= '0;
            r_mulDst   <= '0;
        end else if (w_mulStart) begin
            r_busy     <= 1'b1;
            r_mulCnt   <= '0;
            r_mulAcc   <= '0;
            r_mulCand  <= w_opA;
            r_mulPlier <= w_opB;
            r_mulDst   <= dstSel;
        end else if (r_busy) begin
            r_mulAcc   <= w_mulAdd;
            r_mulCand  <= r_mulCand << 1;
            r_mulPlier <= r_mulPlier >> 1;
            r_mulCnt   <= r_mulCnt + c_CNT_ONE;
            if (w_mulDone) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign in_ready = !r_busy;
`else
    assign w_mulStart  = 1'b0;
    assign w_mulDone   = 1'b0;
    assign w_mulResult = '0;
    assign w_mulDst    = '0;
    assign busy        = 1'b0;
    assign in_ready    = 1'b1;
`endif

    // Register file commit, W-stage capture and flags. The W-to-regfile write
    // and a new W capture share the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wbValid   <= 1'b0;
            r_wbDst     <= '0;
            r_wbData    <= '0;
            r_flagZero  <= 1'b0;
            r_flagCarry <= 1'b0;
        end else begin
            if (r_wbValid) begin
                r_regs[r_wbDst] <= r_wbData;
            end
            r_wbValid <= 1'b0;
            if (w_mulDone) begin
                r_wbValid   <= 1'b1;
                r_wbDst     <= w_mulDst;
                r_wbData    <= w_mulResult;
                r_flagZero  <= (w_mulResult == '0);
                r_flagCarry <= 1'b0;
            end else if (w_accept && !w_mulStart) begin
                r_wbValid <= 1'b1;
                r_wbDst   <= dstSel;
                if (muxSel) begin
                    r_wbData <= inputData;
                end else begin
                    r_wbData    <= w_aluRes;
                    r_flagZero  <= (w_aluRes == '0);
                    r_flagCarry <= w_aluCarry;
                end
            end
        end
    end

    assign wb_valid   = r_wbValid;
    assign wb_dst     = r_wbDst;
    assign wb_data    = r_wbData;
    assign flag_zero  = r_flagZero;
    assign flag_carry = r_flagCarry;
    assign rd_data    = r_regs[rd_sel];

endmodule
`default_nettype wire

// File: tb/tb_param_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_datapath
// Purpose  : Self-checking bench for param_datapath (WIDTH=8, NREGS=16).
//            Directed cases plus randomized instructions compared against an
//            architectural model (register array + flags, arithmetic on ints).
//            Follows MULT_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_datapath;

    localparam int WIDTH = 8;
    localparam int NREGS = 16;
    localparam int SEL_W = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             inValid;
    logic             inReady;
    logic             muxSel;
    logic [WIDTH-1:0] inputData;
    logic [SEL_W-1:0] dstSel;
    logic [SEL_W-1:0] aSel;
    logic [SEL_W-1:0] bSel;
    logic [3:0]       opSel;
    logic             wbValid;
    logic [SEL_W-1:0] wbDst;
    logic [WIDTH-1:0] wbData;
    logic             flagZero;
    logic             flagCarry;
    logic             busy;
    logic [SEL_W-1:0] rdSel;
    logic [WIDTH-1:0] rdData;

    param_datapath #(.WIDTH(WIDTH), .NREGS(NREGS), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .muxSel    (muxSel),
        .inputData (inputData),
        .dstSel    (dstSel),
        .A_sel     (aSel),
        .B_sel     (bSel),
        .OP_Sel    (opSel),
        .wb_valid  (wbValid),
        .wb_dst    (wbDst),
        .wb_data   (wbData),
        .flag_zero (flagZero),
        .flag_carry(flagCarry),
        .busy      (busy),
        .rd_sel    (rdSel),
        .rd_data   (rdData)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;

    // Architectural model: every accepted instruction is applied in order.
    int archRegs [NREGS];
    bit fZero;
    bit fCarry;
    bit mulPend;
    int mulRes;
    int mulDst;

    task automatic chkVal(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs != exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void modelOp(input int op, input int a, input int b,
                                    output int res, output bit cy);
        int m;
        m   = 1 << WIDTH;
        cy  = 1'b0;
        res = 0;
        case (op)
            0:  res = 0;
            1:  res = a;
            2:  begin res = a + 1; cy = (res >= m); end
            3:  begin res = a - 1; cy = (a >= 1); end
            4:  begin res = a + b; cy = (res >= m); end
            5:  res = m - a;
            6:  res = a & b;
            7:  res = a | b;
            8:  res = (a == b) ? 1 : 0;
            9:  res = (a > b) ? 1 : 0;
            10: res = a ^ b;
            11: begin res = a - b; cy = (a >= b); end
            12: res = (b >= WIDTH) ? 0 : (a << b);
            13: res = (b >= WIDTH) ? 0 : (a >> b);
`ifdef MULT_EN
            14: res = a * b;
`else
            14: res = 0;
`endif
            15: res = m - 1 - a;
            default: res = 0;
        endcase
        res = res & (m - 1);
    endfunction

    task automatic resetModel();
        for (int i = 0; i < NREGS; i++) archRegs[i] = 0;
        fZero   = 1'b0;
        fCarry  = 1'b0;
        mulPend = 1'b0;
    endtask

    // Called at posedge+1 with the next instruction (if any) already held on
    // the inputs. Runs out a pending multiply and checks its writeback.
    task automatic waitMul();
        int cyc;
        if (!mulPend) return;
        cyc = 0;
        while (busy === 1'b1 && cyc < WIDTH + 4) begin
            chkVal("mul_hold_ready", int'(inReady), 0);
            chkVal("mul_wb_idle", int'(wbValid), 0);
            @(posedge clk); #1;
            cyc++;
        end
        chkVal("mul_cycles", cyc, WIDTH);
        chkVal("mul_wb_valid", int'(wbValid), 1);
        chkVal("mul_wb_dst", int'(wbDst), mulDst);
        chkVal("mul_wb_data", int'(wbData), mulRes);
        chkVal("mul_zero", int'(flagZero), (mulRes == 0) ? 1 : 0);
        chkVal("mul_carry", int'(flagCarry), 0);
        fZero  = (mulRes == 0);
        fCarry = 1'b0;
        archRegs[mulDst] = mulRes;
        mulPend = 1'b0;
    endtask

    task automatic issue(input bit ms, input int data, input int dst,
                         input int a, input int b, input int op);
        int res;
        bit cy;
        int rs;
        inValid   = 1'b1;
        muxSel    = ms;
        inputData = WIDTH'(data);
        dstSel    = SEL_W'(dst);
        aSel      = SEL_W'(a);
        bSel      = SEL_W'(b);
        opSel     = 4'(op);
        waitMul();
        cy = 1'b0;
        if (ms) res = data & MASK;
        else    modelOp(op, archRegs[a], archRegs[b], res, cy);
        rs    = $urandom_range(0, NREGS - 1);
        rdSel = SEL_W'(rs);
        @(posedge clk); #1;
        inValid = 1'b0;
        // Everything accepted before this instruction is now in the regfile.
        chkVal("rd_data", int'(rdData), archRegs[rs]);
`ifdef MULT_EN
        if (!ms && op == 14) begin
            chkVal("mul_busy", int'(busy), 1);
            chkVal("mul_ready", int'(inReady), 0);
            chkVal("mul_accept_wb", int'(wbValid), 0);
            mulPend = 1'b1;
            mulRes  = res;
            mulDst  = dst;
            return;
        end
`endif
        if (!ms) begin
            fZero  = (res == 0);
            fCarry = cy;
        end
        chkVal("wb_valid", int'(wbValid), 1);
        chkVal("wb_dst", int'(wbDst), dst);
        chkVal("wb_data", int'(wbData), res);
        chkVal("flag_zero", int'(flagZero), int'(fZero));
        chkVal("flag_carry", int'(flagCarry), int'(fCarry));
        chkVal("busy_idle", int'(busy), 0);
        archRegs[dst] = res;
    endtask

    // Reads one register through the debug port, one cycle per read.
    task automatic readReg(input int r, output int v);
        rdSel = SEL_W'(r);
        #4;
        v = int'(rdData);
        #6;
    endtask

    task automatic drain();
        int v;
        inValid = 1'b0;
        waitMul();
        @(posedge clk); #1;
        chkVal("drain_wb_valid", int'(wbValid), 0);
        for (int r = 0; r < NREGS; r++) begin
            readReg(r, v);
            chkVal("drain_reg", v, archRegs[r]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        resetModel();
        rst       = 1'b1;
        inValid   = 1'b1;
        muxSel    = 1'b1;
        inputData = 8'h55;
        dstSel    = 4'd3;
        aSel      = 4'd0;
        bSel      = 4'd0;
        opSel     = 4'd4;
        rdSel     = 4'd0;

        // Reset dominates a pending request.
        repeat (3) begin
            @(posedge clk); #1;
            chkVal("rst_wb_valid", int'(wbValid), 0);
            chkVal("rst_ready", int'(inReady), 1);
            chkVal("rst_zero", int'(flagZero), 0);
            chkVal("rst_carry", int'(flagCarry), 0);
            chkVal("rst_busy", int'(busy), 0);
        end
        rst     = 1'b0;
        inValid = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            readReg(r, v);
            chkVal("rst_reg", v, 0);
        end

        // Load, load, dependent ADD through the bypass.
        issue(1, 2, 0, 0, 0, 0);
        issue(1, 4, 1, 0, 0, 0);
        issue(0, 0, 15, 0, 1, 4);
        chkVal("add_bypass", int'(wbData), 6);
        chkVal("add_bypass_z", int'(flagZero), 0);
        chkVal("add_bypass_c", int'(flagCarry), 0);

        // Carry out of ADD, SUB to zero, GT and EQ.
        issue(1, 200, 4, 0, 0, 0);
        issue(1, 100, 5, 0, 0, 0);
        issue(0, 0, 6, 4, 5, 4);
        chkVal("add_wrap", int'(wbData), 44);
        chkVal("add_wrap_c", int'(flagCarry), 1);
        issue(1, 8, 2, 0, 0, 0);
        issue(0, 0, 7, 2, 2, 11);
        chkVal("sub_zero", int'(wbData), 0);
        chkVal("sub_zero_z", int'(flagZero), 1);
        chkVal("sub_zero_c", int'(flagCarry), 1);
        issue(1, 33, 12, 0, 0, 0);
        chkVal("load_keeps_z", int'(flagZero), 1);
        issue(0, 0, 7, 1, 2, 9);
        chkVal("gt_false", int'(wbData), 0);
        issue(0, 0, 7, 2, 2, 8);
        chkVal("eq_true", int'(wbData), 1);

        // NEG and carry-producing add of its result; shifts past WIDTH.
        issue(0, 0, 11, 2, 0, 5);
        chkVal("neg", int'(wbData), 8'hF8);
        issue(1, 16, 3, 0, 0, 0);
        issue(0, 0, 10, 3, 11, 4);
        chkVal("add_neg", int'(wbData), 8);
        chkVal("add_neg_c", int'(flagCarry), 1);
        issue(1, 1, 8, 0, 0, 0);
        issue(1, 9, 9, 0, 0, 0);
        issue(0, 0, 13, 8, 9, 12);
        chkVal("shl_big", int'(wbData), 0);

        // Bitwise ops.
        issue(1, 8'hAA, 8, 0, 0, 0);
        issue(1, 8'hCC, 9, 0, 0, 0);
        issue(0, 0, 13, 8, 9, 6);
        chkVal("and", int'(wbData), 8'h88);
        issue(0, 0, 13, 8, 9, 7);
        chkVal("or", int'(wbData), 8'hEE);
        issue(0, 0, 13, 8, 9, 10);
        chkVal("xor", int'(wbData), 8'h66);

        // Multiply, then a dependent instruction held on in_valid.
        issue(1, 13, 12, 0, 0, 0);
        issue(1, 11, 13, 0, 0, 0);
        issue(0, 0, 14, 12, 13, 14);
        issue(0, 0, 7, 14, 0, 4);
        drain();
        readReg(15, v);
        chkVal("r15_add", v, 6);
        readReg(14, v);
`ifdef MULT_EN
        chkVal("mul_13x11", v, 143);
`else
        chkVal("mul_disabled", v, 0);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 250; n++) begin
            issue(($urandom_range(0, 3) == 0), $urandom_range(0, MASK),
                  $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                  $urandom_range(0, NREGS - 1), $urandom_range(0, 15));
        end
        drain();

`ifdef MULT_EN
        // Reset part way through a multiply: no writeback may follow.
        issue(0, 0, 9, 12, 13, 14);
        repeat (3) begin @(posedge clk); #1; end
        chkVal("mid_mul_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        resetModel();
        chkVal("abort_busy", int'(busy), 0);
        chkVal("abort_ready", int'(inReady), 1);
        chkVal("abort_wb", int'(wbValid), 0);
        repeat (WIDTH + 2) begin
            @(posedge clk); #1;
            chkVal("abort_no_wb", int'(wbValid), 0);
        end
        for (int r = 0; r < NREGS; r++) begin
            readReg(r, v);
            chkVal("abort_reg", v, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
